// File: rtl/matvec_pkg.sv
// Purpose: shared sizes and state encoding for the matvec8 stream transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matvec_pkg;

    localparam int K         = 8;
    localparam int DW        = 14;
    localparam int ODW       = 28;
    localparam int MAT_AW    = $clog2(K * K);
    localparam int VEC_AW    = $clog2(K);
    localparam int MAT_WORDS = K * K;
    localparam int TX_WORDS  = K * K + K;
    localparam int IDX_W     = $clog2(K * K + K);

    typedef enum logic [1:0] {
        IDLE,
        SEND_MAT,
        SEND_VEC
    } tx_state_e;

endpackage

// File: rtl/matvec_tx_buf.sv
// Purpose: small register file, one write port, one combinational read port.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; the caller gates i_wr_en.
// Ports: i_clk, i_wr_en/i_wr_addr/i_wr_data (write), i_rd_addr -> o_rd_data (read).
module matvec_tx_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 14
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    // Contents are deliberately not reset; software reloads them as needed.
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/matvec_stream_tx.sv
// Purpose: serialise a buffered K*K matrix + K vector (or vector only) onto the matvec8 input stream.
// Latency: start sampled at edge N -> first word valid in cycle N+1; one word per cycle while ready.
// Backpressure: valid/ready; data and new_matrix hold while valid && !ready.
// Ports: i_clk, i_reset (sync, active-high), matrix/vector write ports, i_start/i_send_matrix,
//        o_busy/o_done/o_wr_err status, o_output_valid/i_output_ready/o_output_data/o_new_matrix stream,
//        o_stall_cnt (live only when MATVEC_TX_PERF_EN is defined, else tied to 0).
module matvec_stream_tx
    import matvec_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mat_wr_en,
    input  logic [MAT_AW-1:0] i_mat_wr_addr,
    input  logic [DW-1:0]     i_mat_wr_data,
    input  logic              i_vec_wr_en,
    input  logic [VEC_AW-1:0] i_vec_wr_addr,
    input  logic [DW-1:0]     i_vec_wr_data,
    input  logic              i_start,
    input  logic              i_send_matrix,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wr_err,
    output logic              o_output_valid,
    input  logic              i_output_ready,
    output logic [DW-1:0]     o_output_data,
    output logic              o_new_matrix,
    output logic [31:0]       o_stall_cnt
);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_mat_loaded;
    logic               r_valid;
    logic [DW-1:0]      r_data;
    logic               r_new_matrix;
    logic               r_done;
    logic               r_wr_err;

    logic               w_busy;
    logic               w_hs;
    logic               w_load;
    logic               w_drop;
    logic               w_new_nxt;
    logic               w_done_nxt;
    logic               w_set_loaded;
    logic [DW-1:0]      w_mat_rd;
    logic [DW-1:0]      w_vec_rd;
    logic [DW-1:0]      w_rd_word;

    assign w_busy = (r_state != IDLE);
    assign w_hs   = r_valid & i_output_ready;

    // Writes during a transaction are dropped so the stream never mixes old and new data.
    matvec_tx_buf #(.DEPTH(MAT_WORDS), .AW(MAT_AW), .W(DW)) u_mat_buf (
        .i_clk     (i_clk),
        .i_wr_en   (i_mat_wr_en & ~w_busy),
        .i_wr_addr (i_mat_wr_addr),
        .i_wr_data (i_mat_wr_data),
        .i_rd_addr (w_idx_nxt[MAT_AW-1:0]),
        .o_rd_data (w_mat_rd)
    );

    // r_idx walks the combined stream: 0..K*K-1 matrix, K*K..K*K+K-1 vector.
    // K*K is a multiple of K (K a power of two), so the low bits are the vector index.
    matvec_tx_buf #(.DEPTH(K), .AW(VEC_AW), .W(DW)) u_vec_buf (
        .i_clk     (i_clk),
        .i_wr_en   (i_vec_wr_en & ~w_busy),
        .i_wr_addr (i_vec_wr_addr),
        .i_wr_data (i_vec_wr_data),
        .i_rd_addr (w_idx_nxt[VEC_AW-1:0]),
        .o_rd_data (w_vec_rd)
    );

    assign w_rd_word = (w_state_nxt == SEND_MAT) ? w_mat_rd : w_vec_rd;

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_new_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_set_loaded = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    // A vector-only request before any matrix has gone out is promoted.
                    if (i_send_matrix || !r_mat_loaded) begin
                        w_state_nxt  = SEND_MAT;
                        w_idx_nxt    = '0;
                        w_new_nxt    = 1'b1;
                        w_set_loaded = 1'b1;
                    end else begin
                        w_state_nxt = SEND_VEC;
                        w_idx_nxt   = IDX_W'(MAT_WORDS);
                    end
                end
            end
            SEND_MAT: begin
                if (w_hs) begin
                    w_load    = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IDX_W'(MAT_WORDS - 1)) begin
                        w_state_nxt = SEND_VEC;
                    end
                end
            end
            SEND_VEC: begin
                if (w_hs) begin
                    if (r_idx == IDX_W'(TX_WORDS - 1)) begin
                        w_drop      = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load    = 1'b1;
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx        <= '0;
            r_mat_loaded <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_new_matrix <= 1'b0;
            r_done       <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;
            if (w_set_loaded) begin
                r_mat_loaded <= 1'b1;
            end
            if ((i_mat_wr_en | i_vec_wr_en) & w_busy) begin
                r_wr_err <= 1'b1;
            end
            if (w_load) begin
                r_valid      <= 1'b1;
                r_data       <= w_rd_word;
                r_new_matrix <= w_new_nxt;
            end else if (w_drop) begin
                r_valid      <= 1'b0;
                r_new_matrix <= 1'b0;
            end
        end
    end

`ifdef MATVEC_TX_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !i_output_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_busy         = w_busy;
    assign o_done         = r_done;
    assign o_wr_err       = r_wr_err;
    assign o_output_valid = r_valid;
    assign o_output_data  = r_data;
    assign o_new_matrix   = r_new_matrix;

endmodule

// File: tb/tb_matvec_stream_tx.sv
// Purpose: directed self-checking bench for matvec_stream_tx.
// Latency: n/a.
// Backpressure: drives i_output_ready high or pseudo-randomly.
module tb_matvec_stream_tx;
    import matvec_pkg::*;

    logic              i_clk;
    logic              i_reset;
    logic              i_mat_wr_en;
    logic [MAT_AW-1:0] i_mat_wr_addr;
    logic [DW-1:0]     i_mat_wr_data;
    logic              i_vec_wr_en;
    logic [VEC_AW-1:0] i_vec_wr_addr;
    logic [DW-1:0]     i_vec_wr_data;
    logic              i_start;
    logic              i_send_matrix;
    logic              o_busy;
    logic              o_done;
    logic              o_wr_err;
    logic              o_output_valid;
    logic              i_output_ready;
    logic [DW-1:0]     o_output_data;
    logic              o_new_matrix;
    logic [31:0]       o_stall_cnt;

    int n_chk;
    int n_err;

    matvec_stream_tx u_dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_mat_wr_en    (i_mat_wr_en),
        .i_mat_wr_addr  (i_mat_wr_addr),
        .i_mat_wr_data  (i_mat_wr_data),
        .i_vec_wr_en    (i_vec_wr_en),
        .i_vec_wr_addr  (i_vec_wr_addr),
        .i_vec_wr_data  (i_vec_wr_data),
        .i_start        (i_start),
        .i_send_matrix  (i_send_matrix),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_wr_err       (o_wr_err),
        .o_output_valid (o_output_valid),
        .i_output_ready (i_output_ready),
        .o_output_data  (o_output_data),
        .o_new_matrix   (o_new_matrix),
        .o_stall_cnt    (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Buffers hold mat[i]=i+1 and vec[j]=-(j+1).
    function automatic int exp_word(input int idx, input bit mat);
        if (!mat) return -(idx + 1);
        if (idx < K * K) return idx + 1;
        return -(idx - K * K + 1);
    endfunction

    task automatic load_bufs();
        for (int i = 0; i < K * K; i++) begin
            i_mat_wr_en   = 1'b1;
            i_mat_wr_addr = MAT_AW'(i);
            i_mat_wr_data = DW'(i + 1);
            i_vec_wr_en   = (i < K);
            i_vec_wr_addr = VEC_AW'(i % K);
            i_vec_wr_data = DW'(-((i % K) + 1));
            @(negedge i_clk);
        end
        i_mat_wr_en = 1'b0;
        i_vec_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    // Called just after a negedge. Issues start, then walks the stream checking each word.
    task automatic run_tx(input bit sm, input bit exp_mat, input bit rnd, input bit poke,
                          input int abort_at, output int stalls, output int busy_cyc);
        int  n;
        int  k;
        int  cyc;
        bit  stalled;
        bit  aborted;
        int  held_d;
        int  held_n;
        n        = exp_mat ? TX_WORDS : K;
        k        = 0;
        cyc      = 0;
        stalled  = 1'b0;
        aborted  = 1'b0;
        held_d   = 0;
        held_n   = 0;
        stalls   = 0;
        busy_cyc = 0;
        i_start       = 1'b1;
        i_send_matrix = sm;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        @(negedge i_clk);
        chk("first_valid", int'(o_output_valid), 1);
        while (k < n && cyc < 4000 && !aborted) begin
            i_start     = 1'b0;
            i_vec_wr_en = 1'b0;
            if (abort_at == k) begin
                do_reset();
                chk("abort_valid", int'(o_output_valid), 0);
                chk("abort_busy", int'(o_busy), 0);
                chk("abort_newm", int'(o_new_matrix), 0);
                chk("abort_wr_err", int'(o_wr_err), 0);
                aborted = 1'b1;
            end else begin
                if (poke && k == 2) begin
                    i_vec_wr_en   = 1'b1;
                    i_vec_wr_addr = VEC_AW'(3);
                    i_vec_wr_data = DW'(100);
                    i_start       = 1'b1;
                    i_send_matrix = 1'b1;
                end
                i_output_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (o_busy) busy_cyc++;
                chk("valid_hold", int'(o_output_valid), 1);
                if (stalled) begin
                    chk("stall_data", int'($signed(o_output_data)), held_d);
                    chk("stall_newm", int'(o_new_matrix), held_n);
                end
                if (i_output_ready) begin
                    chk("data", int'($signed(o_output_data)), exp_word(k, exp_mat));
                    chk("new_matrix", int'(o_new_matrix), (k == 0 && exp_mat) ? 1 : 0);
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalls++;
                    stalled = 1'b1;
                    held_d  = int'($signed(o_output_data));
                    held_n  = int'(o_new_matrix);
                end
                @(negedge i_clk);
                cyc++;
            end
        end
        i_start        = 1'b0;
        i_vec_wr_en    = 1'b0;
        i_output_ready = 1'b1;
        if (!aborted) begin
            if (k < n) chk("timeout_words", k, n);
            chk("done_pulse", int'(o_done), 1);
            chk("end_valid", int'(o_output_valid), 0);
            chk("end_busy", int'(o_busy), 0);
        end
    endtask

    int st;
    int bc;

    initial begin
        n_chk          = 0;
        n_err          = 0;
        i_reset        = 1'b1;
        i_mat_wr_en    = 1'b0;
        i_mat_wr_addr  = '0;
        i_mat_wr_data  = '0;
        i_vec_wr_en    = 1'b0;
        i_vec_wr_addr  = '0;
        i_vec_wr_data  = '0;
        i_start        = 1'b0;
        i_send_matrix  = 1'b0;
        i_output_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_wr_err", int'(o_wr_err), 0);
        chk("rst_valid", int'(o_output_valid), 0);
        chk("rst_data", int'(o_output_data), 0);
        chk("rst_newm", int'(o_new_matrix), 0);
        chk("rst_stall", int'(o_stall_cnt), 0);

        load_bufs();

        // Full matrix + vector, ready always high.
        run_tx(1'b1, 1'b1, 1'b0, 1'b0, -1, st, bc);
        chk("t1_busy_cycles", bc, TX_WORDS);
        // Vector-only start in the same cycle as done.
        run_tx(1'b0, 1'b0, 1'b0, 1'b0, -1, st, bc);
        chk("t2_busy_cycles", bc, K);
        @(negedge i_clk);
        chk("t2_done_one_cycle", int'(o_done), 0);

        // Reset, then a vector-only request must be promoted to a matrix send.
        do_reset();
        chk("t3_rst_valid", int'(o_output_valid), 0);
        run_tx(1'b0, 1'b1, 1'b0, 1'b0, -1, st, bc);
        chk("t3_busy_cycles", bc, TX_WORDS);

        // Random backpressure during a matrix send.
        run_tx(1'b1, 1'b1, 1'b1, 1'b0, -1, st, bc);
`ifdef MATVEC_TX_PERF_EN
        chk("t4_stall_cnt", int'(o_stall_cnt), st);
`else
        chk("t4_stall_cnt", int'(o_stall_cnt), 0);
`endif
        chk("t4_wr_err_clear", int'(o_wr_err), 0);

        // Write and start while busy: both ignored, wr_err set.
        run_tx(1'b0, 1'b0, 1'b0, 1'b1, -1, st, bc);
        chk("t5_wr_err", int'(o_wr_err), 1);
        @(negedge i_clk);
        chk("t5_no_restart_valid", int'(o_output_valid), 0);
        chk("t5_no_restart_busy", int'(o_busy), 0);
        run_tx(1'b0, 1'b0, 1'b0, 1'b0, -1, st, bc);
        chk("t5_wr_err_sticky", int'(o_wr_err), 1);

        // Reset at word 20 of a matrix send; next vector-only start sends the matrix.
        @(negedge i_clk);
        run_tx(1'b1, 1'b1, 1'b0, 1'b0, 20, st, bc);
        run_tx(1'b0, 1'b1, 1'b0, 1'b0, -1, st, bc);
        chk("t6_busy_cycles", bc, TX_WORDS);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matvec_stream_tx.md
Name: matvec_stream_tx

Overview:
- Transmitter for the input side of the matvec8 matrix-vector multiplier stream.
- Host software or a controller fills a local K*K matrix buffer and a K-entry vector buffer through simple write ports, then issues a start.
- The block serialises the job onto the multiplier's valid/ready input port and drives new_matrix on the first word of each transaction.
- Sits between the system controller and matvec8_part3 in the accelerator datapath.

Parameters:
- K, 8, matrix dimension; matrix is K*K words, vector is K words.
- DW, 14, signed input word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mat_wr_en  in  1  matrix buffer write strobe.
- mat_wr_addr  in  clog2(K*K)  row-major index (row*K+col).
- mat_wr_data  in  DW  signed matrix element.
- vec_wr_en  in  1  vector buffer write strobe.
- vec_wr_addr  in  clog2(K)  vector index.
- vec_wr_data  in  DW  signed vector element.
- start  in  1  begin a transaction; sampled only when busy=0.
- send_matrix  in  1  qualifier of start; 1 = transmit matrix then vector, 0 = vector only.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse after the last word's handshake.
- wr_err  out  1  sticky flag; a buffer write arrived while busy.
- output_valid  out  1  stream valid to the multiplier's input_valid.
- output_ready  in  1  from the multiplier's input_ready.
- output_data  out  DW  to the multiplier's input_data.
- new_matrix  out  1  to the multiplier's new_matrix.
- stall_cnt  out  32  stall cycles (see Optional Feature).

Behaviour:
- Clock is clk. Reset is synchronous and active-high. Everything is single clock.
- Reset values: busy=0, done=0, wr_err=0, output_valid=0, output_data=0, new_matrix=0, stall_cnt=0, state=IDLE, mat_loaded=0. Buffer contents are not reset.
- Stream protocol:
  - A word transfers on a clk edge where output_valid=1 and output_ready=1.
  - Once output_valid is asserted, output_data and new_matrix hold stable until that handshake.
  - output_valid never drops without a handshake, except on reset.
- Transaction format:
  - new_matrix=1 on the first word: K*K matrix words in row-major order, then K vector words.
  - new_matrix=0 on the first word: K vector words only; the multiplier reuses its stored matrix.
  - new_matrix is driven 0 on all non-first words.
- FSM states:
  - IDLE -> SEND_MAT when start=1 and (send_matrix=1 or mat_loaded=0). Sets mat_loaded=1.
  - IDLE -> SEND_VEC when start=1 and send_matrix=0 and mat_loaded=1.
  - SEND_MAT -> SEND_VEC on the handshake of matrix word K*K-1.
  - SEND_VEC -> IDLE on the handshake of vector word K-1, with done=1 for exactly the next cycle.
- Forced matrix: a vector-only start issued before any matrix has been sent since reset is promoted to a matrix send.
- Latency: start sampled at edge N gives output_valid=1 with the first word during cycle N+1, so busy=1 from N+1.
- Back-to-back: with output_ready held high, a transaction is exactly K*K+K or K cycles, with no bubble between words.
- Next start: it may be sampled in the same cycle as done, so the next first word appears one cycle later.
- Data source: each word is read from the buffer at the current index counter and registered. Counter width is clog2(K*K+K).
- Start while busy=1 is ignored.
- Buffer writes:
  - A write while busy=0 takes effect at the edge.
  - A write while busy=1 is dropped and sets wr_err, which is cleared only by reset.
  - mat_wr_en and vec_wr_en may be asserted in the same cycle.
- Reset mid-transaction: the stream aborts immediately, output_valid falls to 0 the cycle after reset, and mat_loaded clears. The next start therefore always sends the matrix.

Optional Feature:
- Macro: MATVEC_TX_PERF_EN.
- Defined: stall_cnt increments on every clk where output_valid=1 and output_ready=0. It saturates at 2^32-1 and is cleared by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package matvec_pkg holds:
  - K, DW, and output width ODW=28.
  - Derived widths MAT_AW=clog2(K*K) and VEC_AW=clog2(K).
  - State enum tx_state_e {IDLE, SEND_MAT, SEND_VEC}.
- Sub-module matvec_tx_buf: a parameterised register file with one write port and one combinational read port, instantiated twice (depth K*K and depth K).

Test Plan:
- Load mat[i]=i+1 (i=0..63) and vec[j]=-(j+1), then start send_matrix=1 with ready held high -> 72 consecutive handshakes carrying 1..64 then -1..-8. new_matrix=1 only on word 0. done pulses one cycle after word 71.
- Immediately start send_matrix=0 -> exactly 8 words -1..-8, new_matrix=0 on all, busy high for 8 cycles.
- After reset, start send_matrix=0 -> promoted to a matrix send: 72 words, new_matrix=1 on the first.
- Randomise output_ready at 50% during a matrix send -> data is stable across every stall, the word order is identical to the first test, and stall_cnt equals the counted stall cycles when MATVEC_TX_PERF_EN is defined (0 otherwise).
- Write vec[3]=100 while busy -> transmitted vector is unchanged and wr_err=1. Start while busy -> ignored.
- Assert reset at word 20 of a matrix send -> output_valid=0 the next cycle, busy=0, and the next start send_matrix=0 still transmits the matrix.
